// File: rtl/hdmi_cfg_sequencer.sv
// ============================================================================
// Module   : hdmi_cfg_sequencer
// Purpose  : Power-up register-table walker that drives a byte-level I2C master
//            and configures the HDMI transmitter, retrying NACKed writes.
// Optional : HDMI_CFG_HPD_REINIT_EN (re-run the table on a tx_int rising edge)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_cfg_sequencer #(
    parameter int          NUM_REGS       = 31,
    parameter int          POWERUP_CYCLES = 1000000,
    parameter logic [7:0]  DEV_ADDR       = 8'h72,
    parameter int          MAX_RETRIES    = 3,
    localparam int         IW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic          start,
    input  logic          tx_int,
    output logic [IW-1:0] tbl_idx,
    input  logic [15:0]   tbl_data,
    output logic          i2c_req,
    output logic [7:0]    i2c_dev,
    output logic [7:0]    i2c_reg,
    output logic [7:0]    i2c_data,
    input  logic          i2c_ack,
    input  logic          i2c_nack,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int             PW          = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam logic [PW-1:0]  C_PWR_INIT  = PW'(POWERUP_CYCLES - 1);
    localparam logic [IW-1:0]  C_LAST_IDX  = IW'(NUM_REGS - 1);
    localparam logic [3:0]     C_MAX_RETRY = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_WAIT_PWR = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_ISSUE    = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t          r_state, w_state_n;
    logic [PW-1:0]   r_pwr_cnt, w_pwr_cnt_n;
    logic [IW-1:0]   r_idx, w_idx_n;
    logic [3:0]      r_retry, w_retry_n;
    logic [7:0]      r_reg, w_reg_n;
    logic [7:0]      r_data, w_data_n;
    logic            w_restart;
    logic            w_idle;

    assign w_idle = (r_state == S_DONE) || (r_state == S_FAIL);

`ifdef HDMI_CFG_HPD_REINIT_EN
    logic r_tx_meta, r_tx_sync, r_tx_prev, r_pend;
    logic w_tx_rise;

    assign w_tx_rise = r_tx_sync & ~r_tx_prev;
    // A hot-plug edge seen mid-sequence is remembered and replayed once idle.
    assign w_restart = start | w_tx_rise | r_pend;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_tx_meta <= 1'b0;
            r_tx_sync <= 1'b0;
            r_tx_prev <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_tx_meta <= tx_int;
            r_tx_sync <= r_tx_meta;
            r_tx_prev <= r_tx_sync;
            if (w_idle && w_restart)
                r_pend <= 1'b0;
            else if (!w_idle && w_tx_rise)
                r_pend <= 1'b1;
        end
    end
`else
    logic w_unused_tx_int;

    assign w_unused_tx_int = tx_int;
    assign w_restart       = start;
`endif

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state   <= S_WAIT_PWR;
            r_pwr_cnt <= C_PWR_INIT;
            r_idx     <= '0;
            r_retry   <= '0;
            r_reg     <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_pwr_cnt <= w_pwr_cnt_n;
            r_idx     <= w_idx_n;
            r_retry   <= w_retry_n;
            r_reg     <= w_reg_n;
            r_data    <= w_data_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pwr_cnt_n = r_pwr_cnt;
        w_idx_n     = r_idx;
        w_retry_n   = r_retry;
        w_reg_n     = r_reg;
        w_data_n    = r_data;
        i2c_req     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;

        case (r_state)
            S_WAIT_PWR: begin
                if (r_pwr_cnt == '0) begin
                    w_state_n = S_FETCH;
                    w_idx_n   = '0;
                end else begin
                    w_pwr_cnt_n = r_pwr_cnt - 1'b1;
                end
            end
            S_FETCH: w_state_n = S_LATCH;
            S_LATCH: begin
                // ROM output is valid here, one cycle after the index settled.
                w_reg_n   = tbl_data[15:8];
                w_data_n  = tbl_data[7:0];
                w_state_n = S_ISSUE;
            end
            S_ISSUE: begin
                i2c_req = 1'b1;
                if (i2c_ack) begin
                    if (!i2c_nack) begin
                        w_retry_n = '0;
                        if (r_idx == C_LAST_IDX) begin
                            w_state_n = S_DONE;
                        end else begin
                            w_idx_n   = r_idx + 1'b1;
                            w_state_n = S_FETCH;
                        end
                    end else if (r_retry < C_MAX_RETRY) begin
                        w_retry_n = r_retry + 1'b1;
                        w_state_n = S_GAP;
                    end else begin
                        w_state_n = S_FAIL;
                    end
                end
            end
            S_GAP: w_state_n = S_ISSUE;
            S_DONE, S_FAIL: begin
                busy  = 1'b0;
                done  = (r_state == S_DONE);
                error = (r_state == S_FAIL);
                if (w_restart) begin
                    w_state_n = S_FETCH;
                    w_idx_n   = '0;
                    w_retry_n = '0;
                end
            end
            default: w_state_n = S_WAIT_PWR;
        endcase
    end

    assign tbl_idx  = r_idx;
    assign i2c_dev  = DEV_ADDR;
    assign i2c_reg  = r_reg;
    assign i2c_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_cfg_sequencer.sv
// ============================================================================
// Module   : tb_hdmi_cfg_sequencer
// Purpose  : Directed self-checking bench: registered ROM, I2C responder that
//            acks 2 cycles after req with scripted NACKs, linear test steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdmi_cfg_sequencer;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic        start;
    logic        tx_int;
    logic [1:0]  tbl_idx;
    logic [15:0] tbl_data = 16'h0000;
    logic        i2c_req;
    logic [7:0]  i2c_dev;
    logic [7:0]  i2c_reg;
    logic [7:0]  i2c_data;
    logic        i2c_ack  = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n;

    logic [15:0] rom [4] = '{16'h10A0, 16'h11A1, 16'h12A2, 16'h13A3};
    logic [16:0] exp_w [4] = '{17'h010A0, 17'h011A1, 17'h012A2, 17'h013A3};

    logic [16:0] log_q [$];
    int          ack_q [$];
    int          rise_q [$];
    int          nack_mode = 0;
    int          nack_cnt  = 0;
    int          m_cnt     = 0;
    logic        prev_req  = 1'b0;

    hdmi_cfg_sequencer #(
        .NUM_REGS       (4),
        .POWERUP_CYCLES (10),
        .DEV_ADDR       (8'h72),
        .MAX_RETRIES    (3)
    ) dut (
        .clk_50   (clk_50),
        .rst      (rst),
        .start    (start),
        .tx_int   (tx_int),
        .tbl_idx  (tbl_idx),
        .tbl_data (tbl_data),
        .i2c_req  (i2c_req),
        .i2c_dev  (i2c_dev),
        .i2c_reg  (i2c_reg),
        .i2c_data (i2c_data),
        .i2c_ack  (i2c_ack),
        .i2c_nack (i2c_nack),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        cyc      <= cyc + 1;
        tbl_data <= rom[tbl_idx];
    end

    // Responder: ack lands in the third cycle of req, i.e. 2 cycles after it rose.
    always @(negedge clk_50) begin
        if (i2c_req && !prev_req)
            rise_q.push_back(cyc);
        prev_req = i2c_req;
        if (rst || !i2c_req) begin
            i2c_ack  = 1'b0;
            i2c_nack = 1'b0;
            m_cnt    = 0;
        end else begin
            m_cnt++;
            if (m_cnt == 3) begin
                if (nack_mode == 1 && i2c_reg == 8'h12 && nack_cnt < 2) begin
                    i2c_nack = 1'b1;
                    nack_cnt++;
                end else if (nack_mode == 2 && i2c_reg == 8'h11) begin
                    i2c_nack = 1'b1;
                end else begin
                    i2c_nack = 1'b0;
                end
                i2c_ack = 1'b1;
                log_q.push_back({i2c_nack, i2c_reg, i2c_data});
                ack_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        ack_q.delete();
        rise_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || error) && k < 400) begin
            @(negedge clk_50);
            k++;
        end
        check({tag, "_timeout"}, 32'(done || error), 32'd1);
    endtask

    task automatic count_to_req(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (!i2c_req && cnt < 100);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        tx_int = 1'b0;
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);

        // Reset state
        check("rst_busy",  32'(busy),     32'd1);
        check("rst_done",  32'(done),     32'd0);
        check("rst_error", 32'(error),    32'd0);
        check("rst_req",   32'(i2c_req),  32'd0);
        check("rst_idx",   32'(tbl_idx),  32'd0);
        check("rst_reg",   32'(i2c_reg),  32'd0);
        check("rst_data",  32'(i2c_data), 32'd0);
        check("rst_dev",   32'(i2c_dev),  32'h72);

        // Power-up wait and clean pass
        rst = 1'b0;
        clear_logs();
        count_to_req(n);
        check("pwr_first_req", 32'(n), 32'd12);
        wait_end("t1");
        check("t1_done",  32'(done),  32'd1);
        check("t1_busy",  32'(busy),  32'd0);
        check("t1_error", 32'(error), 32'd0);
        check("t1_idx",   32'(tbl_idx), 32'd3);
        check("t1_nwr",   32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_wr%0d", i), 32'(log_q[i]), 32'(exp_w[i]));
        check("t1_ack_to_req", 32'(rise_q[1] - ack_q[0]), 32'd3);

        // Entry 2 NACKed twice then accepted
        clear_logs();
        nack_mode = 1;
        nack_cnt  = 0;
        pulse_start();
        wait_end("t2");
        check("t2_done",  32'(done),  32'd1);
        check("t2_error", 32'(error), 32'd0);
        check("t2_nwr",   32'(log_q.size()), 32'd6);
        check("t2_att0",  32'(log_q[2]), 32'h112A2);
        check("t2_att1",  32'(log_q[3]), 32'h112A2);
        check("t2_att2",  32'(log_q[4]), 32'h012A2);
        check("t2_last",  32'(log_q[5]), 32'h013A3);
        check("t2_gap0",  32'(rise_q[3] - ack_q[2]), 32'd2);
        check("t2_gap1",  32'(rise_q[4] - ack_q[3]), 32'd2);
        check("t2_next",  32'(rise_q[5] - ack_q[4]), 32'd3);

        // Entry 1 always NACKed: retries exhausted
        clear_logs();
        nack_mode = 2;
        pulse_start();
        wait_end("t3");
        check("t3_error", 32'(error), 32'd1);
        check("t3_done",  32'(done),  32'd0);
        check("t3_busy",  32'(busy),  32'd0);
        check("t3_idx",   32'(tbl_idx), 32'd1);
        check("t3_nwr",   32'(log_q.size()), 32'd5);
        check("t3_lastatt", 32'(log_q[4]), 32'h111A1);
        nack_mode = 0;
        clear_logs();
        pulse_start();
        check("t3_err_clr", 32'(error), 32'd0);
        check("t3_rebusy",  32'(busy),  32'd1);
        wait_end("t3b");
        check("t3b_done", 32'(done), 32'd1);
        check("t3b_nwr",  32'(log_q.size()), 32'd4);
        check("t3b_wr0",  32'(log_q[0]), 32'(exp_w[0]));

        // Start from DONE: no power-up wait; start while busy ignored
        clear_logs();
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        n = 1;
        while (!i2c_req && n < 50) begin
            @(negedge clk_50);
            n++;
        end
        check("t4_start_lat", 32'(n), 32'd3);
        check("t4_done_clr",  32'(done), 32'd0);
        n = 0;
        while (!(i2c_req && tbl_idx == 2'd2) && n < 100) begin
            @(negedge clk_50);
            n++;
        end
        check("t4_reach_e2", 32'(i2c_req && tbl_idx == 2'd2), 32'd1);
        pulse_start();
        wait_end("t4");
        check("t4_nwr",  32'(log_q.size()), 32'd4);
        check("t4_wr3",  32'(log_q[3]), 32'(exp_w[3]));
        check("t4_done", 32'(done), 32'd1);

`ifdef HDMI_CFG_HPD_REINIT_EN
        // Hot-plug edge in DONE restarts; edge while busy queues a second pass
        clear_logs();
        tx_int = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk_50);
            n++;
        end
        check("hpd_rerun_lat", 32'(busy && n <= 4), 32'd1);
        wait_end("hpd1");
        check("hpd1_nwr", 32'(log_q.size()), 32'd4);
        tx_int = 1'b0;
        repeat (4) @(negedge clk_50);
        check("hpd_idle", 32'(done), 32'd1);
        clear_logs();
        pulse_start();
        repeat (5) @(negedge clk_50);
        tx_int = 1'b1;
        wait_end("hpd2");
        @(negedge clk_50);
        check("hpd2_repass", 32'(busy), 32'd1);
        wait_end("hpd3");
        check("hpd3_nwr", 32'(log_q.size()), 32'd8);
        tx_int = 1'b0;
`else
        // tx_int is ignored in the default build
        clear_logs();
        tx_int = 1'b1;
        repeat (20) @(negedge clk_50);
        tx_int = 1'b0;
        repeat (20) @(negedge clk_50);
        check("txint_busy", 32'(busy), 32'd0);
        check("txint_done", 32'(done), 32'd1);
        check("txint_req",  32'(rise_q.size()), 32'd0);
`endif

        // Reset in the middle of a request
        clear_logs();
        pulse_start();
        count_to_req(n);
        check("t5_req_seen", 32'(i2c_req), 32'd1);
        rst = 1'b1;
        @(negedge clk_50);
        check("t5_req_drop", 32'(i2c_req), 32'd0);
        check("t5_busy",     32'(busy),    32'd1);
        check("t5_done",     32'(done),    32'd0);
        rst = 1'b0;
        count_to_req(n);
        check("t5_pwr_again", 32'(n), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hdmi_cfg_sequencer.md
Name: hdmi_cfg_sequencer

Overview:
- Controller that configures the HDMI transmitter after power-up.
- Walks a table of {register, value} pairs and issues one register write per entry to a byte-level I2C master over a req/ack handshake.
- Retries entries the device NACKs, and reports done or error status.
- Sits between the external register table and the I2C master, in the HDMI config path, on the 50 MHz board clock.

Parameters:
- NUM_REGS, 31, number of table entries, 1..256.
- POWERUP_CYCLES, 1000000, clk_50 cycles to wait after reset before the first write (20 ms).
- DEV_ADDR, 8'h72, 8-bit I2C write address of the transmitter.
- MAX_RETRIES, 3, extra attempts per entry after a NACK, 0..15.

Ports:
- clk_50  in  1  board clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; re-runs the table from entry 0 with no power-up wait.
- tx_int  in  1  transmitter interrupt/hot-plug line; asynchronous.
- tbl_idx  out  IW  table index; IW = max(1, $clog2(NUM_REGS)).
- tbl_data  in  16  {reg[15:8], value[7:0]}; valid one cycle after tbl_idx changes (registered ROM).
- i2c_req  out  1  write request to the I2C master.
- i2c_dev  out  8  always DEV_ADDR.
- i2c_reg  out  8  register address.
- i2c_data  out  8  register value.
- i2c_ack  in  1  one-cycle completion pulse from the I2C master.
- i2c_nack  in  1  device NACK; meaningful only in the cycle i2c_ack is high.
- busy  out  1  sequence in progress.
- done  out  1  all entries written.
- error  out  1  an entry exhausted its retries.

Behaviour:
- Reset values:
  - state = WAIT_PWR, power counter = POWERUP_CYCLES-1.
  - tbl_idx, i2c_req, i2c_reg, i2c_data, done, error = 0; busy = 1.
  - retry counter = 0.
  - tx_int synchroniser flops = 0.
- Reset asserted mid-transaction: i2c_req drops the next cycle and the sequence restarts in WAIT_PWR. The I2C master is responsible for its own abort.
- WAIT_PWR: counter decrements each cycle. When it is 0, go to FETCH with tbl_idx = 0.
- FETCH (1 cycle): tbl_idx is stable; go to LATCH.
- LATCH (1 cycle): capture tbl_data into i2c_reg/i2c_data; go to ISSUE.
- ISSUE:
  - i2c_req = 1. i2c_reg and i2c_data stay stable until i2c_ack is sampled.
  - i2c_req is low in the cycle after ack.
  - i2c_ack=1, i2c_nack=0:
    - Clear the retry counter.
    - If tbl_idx == NUM_REGS-1, go to DONE.
    - Otherwise tbl_idx+1 and go to FETCH.
  - i2c_ack=1, i2c_nack=1:
    - If retries < MAX_RETRIES: retries+1, go to GAP (1 cycle, req low), then back to ISSUE with the same data.
    - Otherwise go to FAIL.
- Latency: ack at cycle t → next i2c_req rises at t+3.
- DONE: done = 1, busy = 0, held. A start pulse clears done and goes to FETCH with tbl_idx = 0.
- FAIL: error = 1, busy = 0, held. tbl_idx keeps the failing index. A start pulse clears error and restarts at entry 0.
- busy = 1 in WAIT_PWR, FETCH, LATCH, ISSUE and GAP.
- start while busy: ignored. start in the same cycle as the final ack: ack is processed, start is ignored.
- i2c_ack outside ISSUE: ignored.
- NUM_REGS = 1: a single write, then DONE.
- tx_int passes through a 2-flop synchroniser (tx_int_s); it is used only by the optional feature.

Optional Feature:
- Macro: HDMI_CFG_HPD_REINIT_EN.
- With the macro defined:
  - A rising edge of tx_int_s while in DONE or FAIL acts exactly like start.
  - A rising edge while busy is latched in a 1-bit pending flag; the restart happens on entry to DONE/FAIL.
  - The pending flag is cleared by that restart and by rst.
- Without the macro: tx_int is unused; no synchroniser or pending flag is generated; only start restarts the sequence.

Test Plan:
- POWERUP_CYCLES=10, NUM_REGS=4, I2C model acks 2 cycles after req:
  - first i2c_req at cycle 12 after rst release (10 wait cycles + FETCH + LATCH);
  - entries 0..3 written in order with the correct reg/data from tbl_data;
  - done=1 and busy=0 after the 4th ack.
- Entry 2 NACKed twice, MAX_RETRIES=3 → three requests with identical reg/data, one idle cycle between attempts; completes with done=1, error=0.
- Entry 1 always NACKed, MAX_RETRIES=3 → exactly 4 attempts, then error=1, done=0, tbl_idx=1. start → error=0, rewrite from entry 0.
- start pulsed during entry 2 ISSUE → no effect; start after done → done=0, first req 3 cycles later with no power-up wait.
- rst asserted while i2c_req=1 → req low next cycle, busy=1, WAIT_PWR restarts the full 10-cycle count.
- With HDMI_CFG_HPD_REINIT_EN:
  - tx_int rising in DONE → re-run begins within 4 cycles;
  - tx_int rising while busy → a second full pass follows immediately after done.
  - Without the macro, tx_int toggles cause no activity.
